// File: rtl/flash_spi_pkg.sv
// Shared definitions for the configuration-flash SPI reader: FSM state encoding
// and the flash opcodes the bridge is expected to issue.
package flash_spi_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CS_SETUP   = 3'd1,
    SHIFT_OP   = 3'd2,
    SHIFT_ADDR = 3'd3,
    SHIFT_RD   = 3'd4,
    WAIT       = 3'd5,
    CS_HOLD    = 3'd6
  } state_t;

  localparam logic [7:0] FLASH_OP_READ = 8'h03;
  localparam logic [7:0] FLASH_OP_RDID = 8'h9F;
  localparam logic [7:0] FLASH_OP_RDSR = 8'h05;

endpackage

// File: rtl/spi_byte_shifter.sv
// One SPI mode-0 byte: SCK low/high for CLK_DIV cycles each, MOSI MSB first on
// falling edges, MISO shifted in on rising edges; a new start may coincide with done.
module spi_byte_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       load,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic          active_reg;
  logic [DW-1:0] div_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    sr_reg;
  logic          sck_reg;
  logic          mosi_reg;

  assign done    = active_reg && (div_reg == DIV_LAST) && sck_reg && (bit_reg == 3'd7);
  assign rx_byte = sr_reg;
  assign sck     = sck_reg;
  assign mosi    = mosi_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg <= 1'b0;
      div_reg    <= '0;
      bit_reg    <= 3'd0;
      sr_reg     <= 8'h00;
      sck_reg    <= 1'b0;
      mosi_reg   <= 1'b0;
    end else if (abort) begin
      active_reg <= 1'b0;
      div_reg    <= '0;
      bit_reg    <= 3'd0;
      sck_reg    <= 1'b0;
      mosi_reg   <= 1'b0;
    end else if (start) begin
      active_reg <= 1'b1;
      div_reg    <= '0;
      bit_reg    <= 3'd0;
      sr_reg     <= tx_byte;
      sck_reg    <= 1'b0;
      mosi_reg   <= tx_byte[7];
    end else if (active_reg) begin
      if (div_reg == DIV_LAST) begin
        div_reg <= '0;
        if (!sck_reg) begin
          sck_reg <= 1'b1;
          sr_reg  <= {sr_reg[6:0], miso};
        end else begin
          sck_reg <= 1'b0;
          bit_reg <= bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
            active_reg <= 1'b0;
            mosi_reg   <= 1'b0;
          end else begin
            mosi_reg <= sr_reg[7];
          end
        end
      end else begin
        div_reg <= div_reg + 1'b1;
      end
    end else begin
      // While idle, load presents the first opcode bit ahead of the first SCK edge.
      mosi_reg <= load & tx_byte[7];
    end
  end

endmodule

// File: rtl/flash_spi_reader.sv
// SPI master for the configuration flash, driven by the bus bridge FLASH_* handshake:
// sends opcode (+ zero address for READ), then returns one byte per request.
module flash_spi_reader
  import flash_spi_pkg::*;
#(
  parameter int         CLK_DIV     = 2,
  parameter int         ADDR_BYTES  = 3,
  parameter logic [7:0] READ_OPCODE = FLASH_OP_READ
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       flash_enable,
  input  logic [7:0] flash_cmd,
  input  logic       flash_continue_read,
  output logic [7:0] flash_data,
  output logic       flash_busy,
  output logic       FLASH_NCS,
  output logic       FLASH_SCK,
  output logic       FLASH_MOSI,
  input  logic       FLASH_MISO
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam int AW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'((ADDR_BYTES > 0) ? ADDR_BYTES - 1 : 0);

  state_t        state_reg;
  logic [7:0]    cmd_reg;
  logic [7:0]    data_reg;
  logic [CW-1:0] cnt_reg;
  logic [AW-1:0] addr_reg;
  logic          busy_reg;
  logic          ncs_reg;

  logic          abort;
  logic          start;
  logic          load;
  logic          done;
  logic          has_addr;
  logic [7:0]    tx_byte;
  logic [7:0]    rx_byte;

  assign abort    = !flash_enable && (state_reg != IDLE) && (state_reg != CS_HOLD);
  assign has_addr = (cmd_reg == READ_OPCODE) && (ADDR_BYTES > 0);
  assign load     = ((state_reg == IDLE) && flash_enable) || (state_reg == CS_SETUP);

  // Address and read phases both shift out zeros.
  always_comb begin
    tx_byte = 8'h00;
    if (state_reg == IDLE)
      tx_byte = flash_cmd;
    else if (state_reg == CS_SETUP)
      tx_byte = cmd_reg;
  end

  always_comb begin
    start = 1'b0;
    case (state_reg)
      CS_SETUP:             start = (cnt_reg == CNT_LAST);
      SHIFT_OP, SHIFT_ADDR: start = done;
      WAIT:                 start = flash_continue_read;
      default:              start = 1'b0;
    endcase
    if (abort)
      start = 1'b0;
  end

  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk     (clk_in),
    .rst_n   (reset_n),
    .abort   (abort),
    .load    (load),
    .start   (start),
    .tx_byte (tx_byte),
    .rx_byte (rx_byte),
    .done    (done),
    .sck     (FLASH_SCK),
    .mosi    (FLASH_MOSI),
    .miso    (FLASH_MISO)
  );

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cmd_reg   <= 8'h00;
      data_reg  <= 8'h00;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      busy_reg  <= 1'b0;
      ncs_reg   <= 1'b1;
    end else if (abort) begin
      state_reg <= CS_HOLD;
      ncs_reg   <= 1'b1;
      busy_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: if (flash_enable) begin
          cmd_reg   <= flash_cmd;
          ncs_reg   <= 1'b0;
          busy_reg  <= 1'b1;
          cnt_reg   <= '0;
          state_reg <= CS_SETUP;
        end
        CS_SETUP: begin
          if (cnt_reg == CNT_LAST) state_reg <= SHIFT_OP;
          else                     cnt_reg   <= cnt_reg + 1'b1;
        end
        SHIFT_OP: if (done) begin
          addr_reg  <= '0;
          state_reg <= has_addr ? SHIFT_ADDR : SHIFT_RD;
        end
        SHIFT_ADDR: if (done) begin
          if (addr_reg == ADDR_LAST) state_reg <= SHIFT_RD;
          else                       addr_reg  <= addr_reg + 1'b1;
        end
        SHIFT_RD: if (done) begin
          data_reg  <= rx_byte;
          busy_reg  <= 1'b0;
          state_reg <= WAIT;
        end
        WAIT: if (flash_continue_read) begin
          busy_reg  <= 1'b1;
          state_reg <= SHIFT_RD;
        end
        CS_HOLD: begin
          ncs_reg <= 1'b1;
          if (cnt_reg == CNT_LAST) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign FLASH_NCS  = ncs_reg;
  assign flash_data = data_reg;
  assign flash_busy = busy_reg | (flash_enable & (state_reg == IDLE));

endmodule

// File: tb/tb_flash_spi_reader.sv
// Bench for flash_spi_reader with a behavioural SPI flash: READ returns addr^8'hA5,
// RDID returns EF 40 16, anything else returns 8'h5A.
module tb_flash_spi_reader;

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic       flash_enable;
  logic [7:0] flash_cmd;
  logic       flash_continue_read;
  logic [7:0] flash_data;
  logic       flash_busy;
  logic       FLASH_NCS;
  logic       FLASH_SCK;
  logic       FLASH_MOSI;
  logic       FLASH_MISO;

  int n_checks = 0;
  int n_fail   = 0;

  flash_spi_reader #(.CLK_DIV(2), .ADDR_BYTES(3), .READ_OPCODE(8'h03)) dut (
    .clk_in              (clk_in),
    .reset_n             (reset_n),
    .flash_enable        (flash_enable),
    .flash_cmd           (flash_cmd),
    .flash_continue_read (flash_continue_read),
    .flash_data          (flash_data),
    .flash_busy          (flash_busy),
    .FLASH_NCS           (FLASH_NCS),
    .FLASH_SCK           (FLASH_SCK),
    .FLASH_MOSI          (FLASH_MOSI),
    .FLASH_MISO          (FLASH_MISO)
  );

  always #5 clk_in = ~clk_in;

  // Flash model, evaluated on the falling clk edge when all DUT outputs are settled.
  int          m_bits  = 0;
  int          m_rises = 0;
  logic [7:0]  m_op    = 8'h00;
  logic [23:0] m_addr  = 24'h0;
  logic [31:0] m_mosi  = 32'h0;
  logic        m_miso  = 1'b0;
  logic        prev_sck = 1'b0;
  logic        prev_ncs = 1'b1;

  assign FLASH_MISO = m_miso;

  function automatic logic model_bit(input int n, input logic [7:0] op, input logic [23:0] addr);
    int         hdr;
    int         idx;
    int         bn;
    logic [7:0] b;
    hdr = (op == 8'h03) ? 32 : 8;
    if (n < hdr) return 1'b0;
    idx = n - hdr;
    bn  = idx / 8;
    case (op)
      8'h03:   b = (addr[7:0] + 8'(bn)) ^ 8'hA5;
      8'h9F:   b = (bn % 3 == 0) ? 8'hEF : ((bn % 3 == 1) ? 8'h40 : 8'h16);
      default: b = 8'h5A;
    endcase
    return b[7 - (idx % 8)];
  endfunction

  always @(negedge clk_in) begin
    if (prev_ncs && !FLASH_NCS) begin
      m_bits  = 0;
      m_rises = 0;
      m_op    = 8'h00;
      m_addr  = 24'h0;
      m_mosi  = 32'h0;
      m_miso  = 1'b0;
    end
    if (!FLASH_NCS && !prev_sck && FLASH_SCK) begin
      if (m_bits < 8)       m_op   = {m_op[6:0], FLASH_MOSI};
      else if (m_bits < 32) m_addr = {m_addr[22:0], FLASH_MOSI};
      if (m_bits < 32)      m_mosi = {m_mosi[30:0], FLASH_MOSI};
      m_bits  = m_bits + 1;
      m_rises = m_rises + 1;
    end
    if (!FLASH_NCS && prev_sck && !FLASH_SCK)
      m_miso = model_bit(m_bits, m_op, m_addr);
    prev_sck = FLASH_SCK;
    prev_ncs = FLASH_NCS;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Raise enable and return just after the edge on which NCS should fall.
  task automatic open_session(input logic [7:0] cmd);
    flash_cmd    = cmd;
    flash_enable = 1'b1;
    #1;
    check("busy_on_enable", 32'(flash_busy), 32'd1);
    tick();
    check("ncs_fall", 32'(FLASH_NCS), 32'd0);
  endtask

  task automatic wait_busy_low(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (flash_busy && n < bound);
  endtask

  task automatic pulse_continue();
    flash_continue_read = 1'b1;
    tick();
    flash_continue_read = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  cmd;
    int          first_lat;
    int          nbytes;
    logic [39:0] exp_bytes;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int         n;
    logic [7:0] exp_b;

    vecs[0] = '{cmd: 8'h03, first_lat: 162, nbytes: 5, exp_bytes: 40'hA5A4A7A6A1};
    vecs[1] = '{cmd: 8'h9F, first_lat: 66,  nbytes: 2, exp_bytes: 40'hEF40000000};
    vecs[2] = '{cmd: 8'h05, first_lat: 66,  nbytes: 2, exp_bytes: 40'h5A5A000000};

    reset_n             = 1'b0;
    flash_enable        = 1'b0;
    flash_cmd           = 8'h00;
    flash_continue_read = 1'b0;
    repeat (3) tick();
    check("rst_ncs",  32'(FLASH_NCS),  32'd1);
    check("rst_sck",  32'(FLASH_SCK),  32'd0);
    check("rst_mosi", 32'(FLASH_MOSI), 32'd0);
    check("rst_data", 32'(flash_data), 32'h00);
    check("rst_busy", 32'(flash_busy), 32'd0);
    reset_n = 1'b1;
    tick();

    // Full sessions from the vector table, each closed by dropping enable in WAIT.
    for (int v = 0; v < 3; v++) begin
      open_session(vecs[v].cmd);
      wait_busy_low(400, n);
      check("first_latency", 32'(n), 32'(vecs[v].first_lat));
      exp_b = vecs[v].exp_bytes[39 -: 8];
      check("first_byte", 32'(flash_data), 32'(exp_b));
      if (vecs[v].cmd == 8'h03) check("mosi_header", m_mosi, 32'h03000000);
      else                      check("no_addr_phase", 32'(m_rises), 32'd16);
      $display("session cmd=%02h byte0=%02h latency=%0d", vecs[v].cmd, flash_data, n);
      for (int b = 1; b < vecs[v].nbytes; b++) begin
        pulse_continue();
        wait_busy_low(100, n);
        check("next_latency", 32'(n), 32'd32);
        exp_b = vecs[v].exp_bytes[39 - 8*b -: 8];
        check("next_byte", 32'(flash_data), 32'(exp_b));
        check("ncs_held", 32'(FLASH_NCS), 32'd0);
        $display("session cmd=%02h byte%0d=%02h latency=%0d", vecs[v].cmd, b, flash_data, n);
        repeat (40 - 1 - n) tick();
      end
      flash_enable = 1'b0;
      tick();
      check("close_ncs", 32'(FLASH_NCS), 32'd1);
      check("close_busy0", 32'(flash_busy), 32'd1);
      tick();
      check("close_busy1", 32'(flash_busy), 32'd1);
      tick();
      check("close_busy2", 32'(flash_busy), 32'd0);
    end

    // Continue while busy and on the completion cycle: both ignored.
    open_session(8'h9F);
    wait_busy_low(400, n);
    check("t4_first", 32'(flash_data), 32'hEF);
    pulse_continue();
    repeat (9) tick();
    pulse_continue();
    repeat (21) tick();
    check("t4_busy_before_done", 32'(flash_busy), 32'd1);
    pulse_continue();
    check("t4_busy_done", 32'(flash_busy), 32'd0);
    check("t4_data", 32'(flash_data), 32'h40);
    repeat (40) tick();
    check("t4_still_idle", 32'(flash_busy), 32'd0);
    check("t4_data_kept", 32'(flash_data), 32'h40);
    check("t4_one_byte", 32'(m_rises), 32'd24);
    $display("busy-ignore: data=%02h sck_rises=%0d", flash_data, m_rises);

    // Abort together with continue, then re-enable during CS_HOLD.
    flash_enable        = 1'b0;
    flash_continue_read = 1'b1;
    tick();
    flash_continue_read = 1'b0;
    check("t4_abort_ncs", 32'(FLASH_NCS), 32'd1);
    check("t4_abort_busy", 32'(flash_busy), 32'd1);
    check("t4_abort_norise", 32'(m_rises), 32'd24);
    flash_cmd    = 8'h9F;
    flash_enable = 1'b1;
    tick();
    check("hold_busy1", 32'(flash_busy), 32'd1);
    check("hold_ncs1", 32'(FLASH_NCS), 32'd1);
    tick();
    check("hold_busy2", 32'(flash_busy), 32'd1);
    check("hold_ncs2", 32'(FLASH_NCS), 32'd1);
    tick();
    check("reopen_ncs", 32'(FLASH_NCS), 32'd0);
    wait_busy_low(400, n);
    check("reopen_latency", 32'(n), 32'd66);
    check("reopen_data", 32'(flash_data), 32'hEF);
    $display("reopen after hold: data=%02h latency=%0d", flash_data, n);
    flash_enable = 1'b0;
    repeat (3) tick();

    // Drop enable mid-address while SCK is high.
    open_session(8'h03);
    repeat (48) tick();
    check("t5_sck_high", 32'(FLASH_SCK), 32'd1);
    flash_enable = 1'b0;
    tick();
    check("t5_ncs", 32'(FLASH_NCS), 32'd1);
    check("t5_sck", 32'(FLASH_SCK), 32'd0);
    check("t5_mosi", 32'(FLASH_MOSI), 32'd0);
    check("t5_busy0", 32'(flash_busy), 32'd1);
    tick();
    check("t5_busy1", 32'(flash_busy), 32'd1);
    tick();
    check("t5_busy2", 32'(flash_busy), 32'd0);
    check("t5_data", 32'(flash_data), 32'hEF);
    pulse_continue();
    tick();
    check("idle_cont_busy", 32'(flash_busy), 32'd0);
    check("idle_cont_ncs", 32'(FLASH_NCS), 32'd1);
    $display("abort mid-address: data=%02h", flash_data);

    // Asynchronous reset during the read byte.
    open_session(8'h9F);
    repeat (45) tick();
    check("t6_sck_high", 32'(FLASH_SCK), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_ncs", 32'(FLASH_NCS), 32'd1);
    check("t6_sck", 32'(FLASH_SCK), 32'd0);
    check("t6_mosi", 32'(FLASH_MOSI), 32'd0);
    check("t6_data", 32'(flash_data), 32'h00);
    check("t6_busy_en", 32'(flash_busy), 32'd1);
    flash_enable = 1'b0;
    #1;
    check("t6_busy_dis", 32'(flash_busy), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    $display("reset mid-read: data=%02h ncs=%0d", flash_data, FLASH_NCS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
